// File: rtl/decode_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : decode_hazard_unit
// Function : DLX decode stage with load-use stall, branch squash and trap halt
// Revision : 1.0
// ============================================================================
module decode_hazard_unit #(
    parameter int LOAD_STALL  = 1,
    parameter int BRANCH_KILL = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       instr,
    input  logic [ADDR_W-1:0] rs1_val,
    input  logic [ADDR_W-1:0] pc_plus_four,
    output logic              out_valid,
    output logic              reg_wr,
    output logic              ext_op,
    output logic              alu_src,
    output logic              mem_wr,
    output logic              mem_to_reg,
    output logic              sb,
    output logic              jal_wr,
    output logic [4:0]        reg_dst,
    output logic [4:0]        alu_op,
    output logic [1:0]        lb,
    output logic              branch_taken,
    output logic [ADDR_W-1:0] new_pc,
    output logic              stall,
    output logic              halted
);

    typedef enum logic [1:0] {RUN = 2'd0, LSTALL = 2'd1, BKILL = 2'd2, HALT = 2'd3} state_t;

    localparam logic [4:0] c_ALU_AND = 5'b00000;
    localparam logic [4:0] c_ALU_OR  = 5'b00001;
    localparam logic [4:0] c_ALU_ADD = 5'b00010;
    localparam logic [4:0] c_ALU_SUB = 5'b00011;
    localparam logic [4:0] c_ALU_XOR = 5'b00100;
    localparam logic [4:0] c_ALU_SLL = 5'b00101;
    localparam logic [4:0] c_ALU_SRL = 5'b00110;
    localparam logic [4:0] c_ALU_SLT = 5'b01000;
    localparam logic [4:0] c_ALU_SGE = 5'b01001;
    localparam logic [4:0] c_ALU_SGT = 5'b01010;
    localparam logic [4:0] c_ALU_LHI = 5'b01100;
    localparam logic [1:0] c_LOAD_CNT   = 2'(LOAD_STALL - 1);
    localparam logic [1:0] c_BRANCH_CNT = 2'(BRANCH_KILL - 1);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d, reg_wr_q, reg_wr_d, ext_op_q, ext_op_d;
    logic              alu_src_q, alu_src_d, mem_wr_q, mem_wr_d, mem_to_reg_q, mem_to_reg_d;
    logic              sb_q, sb_d, jal_wr_q, jal_wr_d, branch_taken_q, branch_taken_d;
    logic              halted_q, halted_d;
    logic [4:0]        reg_dst_q, reg_dst_d, alu_op_q, alu_op_d;
    logic [1:0]        lb_q, lb_d;
    logic [ADDR_W-1:0] new_pc_q, new_pc_d;

    logic [5:0]        w_op, w_func;
    logic              w_nop, w_rtype, w_jtype, w_load, w_store, w_trap, w_jreg, w_taken;
    logic              w_reg_wr, w_ext_op;
    logic [4:0]        w_reg_dst, w_alu_op;
    logic [ADDR_W-1:0] w_target;

    always_comb begin
        w_op     = instr[31:26];
        w_func   = instr[5:0];
        w_nop    = (w_op == 6'h00) && (w_func == 6'h15);
        w_rtype  = ((w_op == 6'h00) && !w_nop) || (w_op == 6'h01);
        w_jtype  = (w_op == 6'h02) || (w_op == 6'h03) || (w_op == 6'h10) || (w_op == 6'h11);
        w_load   = (w_op == 6'h20) || (w_op == 6'h21) || (w_op == 6'h23) ||
                   (w_op == 6'h24) || (w_op == 6'h25);
        w_store  = (w_op == 6'h28) || (w_op == 6'h29) || (w_op == 6'h2B);
        w_trap   = (w_op == 6'h11);
        w_jreg   = (w_op == 6'h12) || (w_op == 6'h13);
        w_reg_wr = !(w_op == 6'h04 || w_op == 6'h05 || w_jreg || w_store ||
                     w_op == 6'h02 || w_trap || w_nop);
        w_ext_op = (w_op == 6'h08) || (w_op == 6'h0A) || (w_op == 6'h1D) || w_load || w_store;

        if (w_op == 6'h03)    w_reg_dst = 5'd31;
        else if (w_rtype)     w_reg_dst = instr[15:11];
        else if (w_jtype)     w_reg_dst = 5'd0;
        else                  w_reg_dst = instr[20:16];

        // Only opcode 0x00 carries an ALU function field worth decoding.
        w_alu_op = c_ALU_AND;
        if (w_op == 6'h00 && !w_nop) begin
            case (w_func)
                6'h20, 6'h21: w_alu_op = c_ALU_ADD;
                6'h22, 6'h23: w_alu_op = c_ALU_SUB;
                6'h24:        w_alu_op = c_ALU_AND;
                6'h25:        w_alu_op = c_ALU_OR;
                6'h26:        w_alu_op = c_ALU_XOR;
                6'h04:        w_alu_op = c_ALU_SLL;
                6'h06:        w_alu_op = c_ALU_SRL;
                6'h2A:        w_alu_op = c_ALU_SLT;
                6'h2B:        w_alu_op = c_ALU_SGT;
                6'h2D:        w_alu_op = c_ALU_SGE;
                default:      w_alu_op = c_ALU_AND;
            endcase
        end else if (w_op == 6'h08 || w_op == 6'h09 || w_load || w_store) begin
            w_alu_op = c_ALU_ADD;
        end else if (w_op == 6'h0A || w_op == 6'h0B) begin
            w_alu_op = c_ALU_SUB;
        end else if (w_op == 6'h1D) begin
            w_alu_op = c_ALU_SGE;
        end else if (w_op == 6'h0F) begin
            w_alu_op = c_ALU_LHI;
        end

        w_taken  = 1'b0;
        w_target = rs1_val;
        case (w_op)
            6'h04, 6'h05: begin
                w_taken  = (w_op == 6'h04) ? (rs1_val == '0) : (rs1_val != '0);
                w_target = pc_plus_four + {{(ADDR_W-16){instr[15]}}, instr[15:0]};
            end
            6'h02, 6'h03: begin
                w_taken  = 1'b1;
                w_target = pc_plus_four + {{(ADDR_W-26){instr[25]}}, instr[25:0]};
            end
            6'h12, 6'h13: w_taken = 1'b1;
            default:      w_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        out_valid_d    = 1'b0;
        reg_wr_d       = 1'b0;
        ext_op_d       = 1'b0;
        alu_src_d      = 1'b0;
        mem_wr_d       = 1'b0;
        mem_to_reg_d   = 1'b0;
        sb_d           = 1'b0;
        jal_wr_d       = 1'b0;
        reg_dst_d      = 5'd0;
        alu_op_d       = 5'd0;
        lb_d           = 2'b00;
        branch_taken_d = 1'b0;
        new_pc_d       = new_pc_q;
        halted_d       = halted_q;
        case (state_q)
            RUN: begin
                if (in_valid && w_trap) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else if (in_valid) begin
                    out_valid_d  = 1'b1;
                    reg_wr_d     = w_reg_wr;
                    ext_op_d     = w_ext_op;
                    alu_src_d    = w_rtype;
                    mem_wr_d     = w_store;
                    mem_to_reg_d = w_load;
                    sb_d         = (w_op == 6'h28);
                    jal_wr_d     = (w_op == 6'h03);
                    reg_dst_d    = w_reg_dst;
                    alu_op_d     = w_alu_op;
                    lb_d         = {w_op == 6'h24, w_op == 6'h20};
                    if (w_taken) begin
                        branch_taken_d = 1'b1;
                        new_pc_d       = w_target;
                        state_d        = BKILL;
                        cnt_d          = c_BRANCH_CNT;
                    end else if (w_load) begin
                        state_d = LSTALL;
                        cnt_d   = c_LOAD_CNT;
                    end
                end
            end
            LSTALL, BKILL: begin
                if (cnt_q == 2'd0) state_d = RUN;
                else               cnt_d   = cnt_q - 2'd1;
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RUN;
            cnt_q          <= 2'd0;
            out_valid_q    <= 1'b0;
            reg_wr_q       <= 1'b0;
            ext_op_q       <= 1'b0;
            alu_src_q      <= 1'b0;
            mem_wr_q       <= 1'b0;
            mem_to_reg_q   <= 1'b0;
            sb_q           <= 1'b0;
            jal_wr_q       <= 1'b0;
            reg_dst_q      <= 5'd0;
            alu_op_q       <= 5'd0;
            lb_q           <= 2'b00;
            branch_taken_q <= 1'b0;
            new_pc_q       <= '0;
            halted_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            out_valid_q    <= out_valid_d;
            reg_wr_q       <= reg_wr_d;
            ext_op_q       <= ext_op_d;
            alu_src_q      <= alu_src_d;
            mem_wr_q       <= mem_wr_d;
            mem_to_reg_q   <= mem_to_reg_d;
            sb_q           <= sb_d;
            jal_wr_q       <= jal_wr_d;
            reg_dst_q      <= reg_dst_d;
            alu_op_q       <= alu_op_d;
            lb_q           <= lb_d;
            branch_taken_q <= branch_taken_d;
            new_pc_q       <= new_pc_d;
            halted_q       <= halted_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign reg_wr       = reg_wr_q;
    assign ext_op       = ext_op_q;
    assign alu_src      = alu_src_q;
    assign mem_wr       = mem_wr_q;
    assign mem_to_reg   = mem_to_reg_q;
    assign sb           = sb_q;
    assign jal_wr       = jal_wr_q;
    assign reg_dst      = reg_dst_q;
    assign alu_op       = alu_op_q;
    assign lb           = lb_q;
    assign branch_taken = branch_taken_q;
    assign new_pc       = new_pc_q;
    assign halted       = halted_q;
    // The only unregistered output: it must hold IF/ID in the same cycle.
    assign stall        = (state_q == LSTALL) || (state_q == HALT);

endmodule
`default_nettype wire
